// File: rtl/tim_arb_pkg.sv
// tim_arb_pkg: FSM states, requester indices and default timeout for tim_apb_arb
package tim_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  localparam int TOUT_CYC_DEF = 16;
endpackage

// File: rtl/tim_rr_arb.sv
// tim_rr_arb: 2-way round-robin grant; after reset m0 wins a tie
module tim_rr_arb
  import tim_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt,
  output logic       gnt_valid
);
  logic last;
  // on a tie the requester not granted last wins
  always_comb begin
    gnt_valid = |req;
    gnt = (&req) ? ~last : req[M1];
  end
  // remember who was granted when the grant is taken
  always_ff @(posedge clk or posedge rst)
    if (rst) last <= M1;
    else if (take && gnt_valid) last <= gnt;
endmodule

// File: rtl/tim_apb_arb.sv
// tim_apb_arb: shares one APB timer completer between two requesters; define TIM_ARB_TOUT_EN for an ACCESS timeout
module tim_apb_arb
  import tim_arb_pkg::*;
#(
  parameter int TOUT_CYC = TOUT_CYC_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_strb,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_strb,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        tim_psel,
  output logic        tim_penable,
  output logic        tim_pwrite,
  output logic [31:0] tim_paddr,
  output logic [31:0] tim_pwdata,
  output logic [3:0]  tim_pstrb,
  input  logic [31:0] tim_prdata,
  input  logic        tim_pready,
  input  logic        tim_pslverr
);
  state_t      state;
  logic        gnt, gnt_valid, sel, tout;
  logic        w_write;
  logic [31:0] w_addr, w_wdata;
  logic [3:0]  w_strb;
  logic [1:0]  done_q;
  logic [31:0] rdata_q;
  logic        err_q;

  tim_rr_arb u_arb (
    .clk(sys_clk),
    .rst(sys_rst),
    .req({m1_req, m0_req}),
    .take(state == IDLE),
    .gnt(gnt),
    .gnt_valid(gnt_valid)
  );

  // fields of the current arbitration winner, strobes zeroed for reads
  always_comb begin
    w_write = gnt ? m1_write : m0_write;
    w_addr  = gnt ? m1_addr : m0_addr;
    w_wdata = gnt ? m1_wdata : m0_wdata;
    w_strb  = w_write ? (gnt ? m1_strb : m0_strb) : 4'h0;
  end

`ifdef TIM_ARB_TOUT_EN
  localparam int CW = $clog2(TOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign tout = (cnt == CW'(TOUT_CYC - 1));
  // count ACCESS cycles that ended without pready, restarting on every SETUP
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) cnt <= '0;
    else if (state == SETUP) cnt <= '0;
    else if (state == ACCESS && !tim_pready) cnt <= cnt + 1'b1;
`else
  assign tout = (TOUT_CYC < 0);
`endif

  // transfer sequencer: latch winner in IDLE, drive APB phases, pulse done
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state       <= IDLE;
      sel         <= M0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
      tim_pstrb   <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (gnt_valid) begin
            sel        <= gnt;
            tim_pwrite <= w_write;
            tim_paddr  <= w_addr;
            tim_pwdata <= w_wdata;
            tim_pstrb  <= w_strb;
            tim_psel   <= 1'b1;
            state      <= SETUP;
          end
        SETUP: begin
          tim_penable <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS:
          if (tim_pready || tout) begin
            tim_psel     <= 1'b0;
            tim_penable  <= 1'b0;
            done_q[sel]  <= 1'b1;
            rdata_q      <= (tim_pready && !tim_pwrite) ? tim_prdata : '0;
            err_q        <= tim_pready ? tim_pslverr : 1'b1;
            state        <= DONE;
          end
        DONE: begin
          done_q  <= '0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end

  assign m0_done  = done_q[M0];
  assign m0_rdata = done_q[M0] ? rdata_q : '0;
  assign m0_err   = done_q[M0] & err_q;
  assign m1_done  = done_q[M1];
  assign m1_rdata = done_q[M1] ? rdata_q : '0;
  assign m1_err   = done_q[M1] & err_q;
endmodule

// File: doc/tim_apb_arb.md
TIM_APB_ARB -- requirements
Module: tim_apb_arb

Interface
REQ-001 SHALL have parameter: TOUT_CYC, 16, maximum ACCESS-phase wait cycles before abort (used only with TIM_ARB_TOUT_EN).
REQ-002 SHALL have ports (clock and reset first):
 sys_clk  in  1  single clock, all logic rising-edge.
 sys_rst  in  1  reset, asynchronous, active-high.
 mN_req  in  1  requester N (N=0,1) transfer request, level, held until mN_done.
 mN_write  in  1  1 = write, 0 = read; stable while mN_req.
 mN_addr  in  32  byte address; stable while mN_req.
 mN_wdata  in  32  write data; stable while mN_req.
 mN_strb  in  4  write byte strobes; stable while mN_req.
 mN_done  out  1  one-cycle completion pulse to requester N.
 mN_rdata  out  32  read data, valid while mN_done.
 mN_err  out  1  error, valid while mN_done.
 tim_psel, tim_penable, tim_pwrite  out  1  APB controls to timer.
 tim_paddr, tim_pwdata  out  32  APB address / write data.
 tim_pstrb  out  4  APB strobes.
 tim_prdata  in  32  APB read data.
 tim_pready, tim_pslverr  in  1  APB ready / error.

Function
REQ-003 SHALL share one APB completer (timer) between two requesters; exactly one transfer in flight.
REQ-004 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
REQ-005 IDLE: if any mN_req sampled high, SHALL select grant, register write/addr/wdata/strb of the winner, and go to SETUP; else stay.
REQ-006 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins; after reset m0 has priority.
REQ-007 SETUP: tim_psel=1, tim_penable=0, exactly one cycle, then ACCESS.
REQ-008 ACCESS: tim_psel=1, tim_penable=1; SHALL remain until tim_pready=1, then capture tim_prdata (reads only, else 0) and tim_pslverr and go to DONE.
REQ-009 DONE: granted mN_done=1 for exactly one cycle with captured rdata/err; other requester's outputs 0; tim_psel=0; then IDLE.
REQ-010 Minimum latency: request seen in IDLE cycle c -> mN_done in cycle c+3 (pready in first ACCESS cycle); back-to-back throughput one transfer per 4 cycles.
REQ-011 Requester SHALL drop mN_req the cycle after mN_done; a request still high in the following IDLE is a new transfer.
REQ-012 tim_paddr/pwdata/pstrb/pwrite SHALL be driven from registered copies and stay stable from SETUP through ACCESS; requester input changes mid-transfer SHALL be ignored.
REQ-013 tim_pstrb SHALL be forced 0 for reads.
REQ-014 A request arriving during a transfer SHALL wait; it is not lost and gains priority per REQ-006.

Reset
REQ-015 sys_rst=1 SHALL asynchronously force FSM to IDLE, all outputs to 0, captured registers to 0, last-grant to m1 (so m0 wins first).
REQ-016 Reset mid-transfer SHALL abort without mN_done; requester reissues after reset release.

Configuration
REQ-017 Macro TIM_ARB_TOUT_EN defined: an ACCESS-cycle counter SHALL abort after TOUT_CYC cycles without pready, going to DONE with mN_err=1, mN_rdata=0; counter clears on each SETUP.
REQ-018 TIM_ARB_TOUT_EN undefined: no counter; ACCESS waits indefinitely for tim_pready.

Structure
REQ-019 Package tim_arb_pkg SHALL hold the FSM state enum, requester index constants (M0=0, M1=1), and default TOUT_CYC.
REQ-020 Grant logic SHALL be sub-module tim_rr_arb (2-way round-robin, last-grant register, grant-valid output).

Verification
REQ-021 m0 write addr 0x04, wdata 0x0000_00A5, strb 0xF, pready immediate -> tim_psel high 2 cycles, m0_done at c+3, m0_err=0.
REQ-022 m0 and m1 reads asserted same cycle after reset -> m0 served first, m1 second; m1_rdata = tim_prdata sampled at m1's pready.
REQ-023 Both requesters held continuously for 4 transfers -> grants alternate m0,m1,m0,m1; each mN_done exactly once per transfer.
REQ-024 Read with pready delayed 3 cycles, pslverr=1 -> ACCESS 4 cycles, mN_err=1, inputs changed mid-transfer not reflected on tim_paddr.
REQ-025 With TIM_ARB_TOUT_EN, pready held 0 -> abort after 16 ACCESS cycles, mN_err=1, mN_rdata=0; without macro, still in ACCESS after 100 cycles.
REQ-026 sys_rst pulsed during ACCESS -> all outputs 0 same cycle, no mN_done; after release m0 wins a simultaneous request.
